chip_bank_tracker: RTL

//  Chip-level DRAM command front end. Decodes one-hot command strobes to a flat

---
 rtl/chip_bank_tracker.sv | 283 ++++++++++++++++++++++++++++
 1 files changed

// File: rtl/chip_bank_tracker.sv
// chip_bank_tracker
//   Chip-level DRAM command front end. Decodes one-hot command strobes to a
//   flat bank index ({bg,ba}), runs a per-bank state machine with tRCD/tRP/tRFC
//   countdown timers and keeps a per-bank open-row table. Illegal or too-early
//   commands are rejected with an error code; accepted reads produce a
//   CL-delayed data-valid pulse.
//
//   Ports:
//     clk, rst            clock (rising edge), synchronous active-high reset
//     halt                freezes timers, bank FSMs, read pipe and command intake
//     ACT..REF            one-hot command strobes
//     bg, ba, row, column command address
//     cmd_accept/cmd_error/err_code  registered result of last cycle's command
//     bank_open           bit i set while bank i is ACTIVE
//     open_row            row table entry of the addressed bank (combinational)
//     rd_valid/rd_bank/rd_col        read data valid pulse and its bank/column
//     err_count           (only with CHIP_ERR_COUNT_EN) saturating error counter
//
//   Build option: define CHIP_ERR_COUNT_EN to add the err_count output.
//
//   Error codes: 1 MULTI, 2 OPEN, 3 CLOSED, 4 BUSY, 5 REFBLK.

module chip_bank_tracker #(
  parameter int ADDRWIDTH     = 17,
  parameter int COLWIDTH      = 10,
  parameter int BANKGROUPS    = 2,
  parameter int BANKSPERGROUP = 2,
  parameter int TRCD          = 4,
  parameter int TRP           = 4,
  parameter int TRFC          = 16,
  parameter int CL            = 5
) (
  input  logic                                          clk,
  input  logic                                          rst,
  input  logic                                          halt,
  input  logic                                          ACT,
  input  logic                                          PR,
  input  logic                                          PRA,
  input  logic                                          RD,
  input  logic                                          RDA,
  input  logic                                          WR,
  input  logic                                          WRA,
  input  logic                                          REF,
  input  logic [$clog2(BANKGROUPS)-1:0]                 bg,
  input  logic [$clog2(BANKSPERGROUP)-1:0]              ba,
  input  logic [ADDRWIDTH-1:0]                          row,
  input  logic [COLWIDTH-1:0]                           column,
  output logic                                          cmd_accept,
  output logic                                          cmd_error,
  output logic [2:0]                                    err_code,
  output logic [BANKGROUPS*BANKSPERGROUP-1:0]           bank_open,
  output logic [ADDRWIDTH-1:0]                          open_row,
  output logic                                          rd_valid,
  output logic [$clog2(BANKGROUPS*BANKSPERGROUP)-1:0]   rd_bank,
  output logic [COLWIDTH-1:0]                           rd_col
`ifdef CHIP_ERR_COUNT_EN
  ,
  output logic [15:0]                                   err_count
`endif
);

  localparam int NBANKS = BANKGROUPS * BANKSPERGROUP;
  localparam int BW     = $clog2(NBANKS);
  localparam int TMAX   = (TRFC > TRCD) ? ((TRFC > TRP) ? TRFC : TRP)
                                        : ((TRCD > TRP) ? TRCD : TRP);
  localparam int TW     = $clog2(TMAX + 1);

  localparam logic [2:0] E_MULTI  = 3'd1;
  localparam logic [2:0] E_OPEN   = 3'd2;
  localparam logic [2:0] E_CLOSED = 3'd3;
  localparam logic [2:0] E_BUSY   = 3'd4;
  localparam logic [2:0] E_REFBLK = 3'd5;

  typedef enum logic [2:0] {
    B_IDLE,
    B_ACTIVATING,
    B_ACTIVE,
    B_PRECHARGING,
    B_REFRESHING
  } bank_state_t;

  // A transient state is held for (duration-1) further edges after the accept
  // edge; a duration of 1 therefore skips the transient state entirely so the
  // destination is visible on the very next cycle.
  localparam bank_state_t ACT_ST = (TRCD == 1) ? B_ACTIVE : B_ACTIVATING;
  localparam bank_state_t PRE_ST = (TRP  == 1) ? B_IDLE   : B_PRECHARGING;
  localparam bank_state_t REF_ST = (TRFC == 1) ? B_IDLE   : B_REFRESHING;
  localparam logic [TW-1:0] ACT_T = TW'(TRCD - 1);
  localparam logic [TW-1:0] PRE_T = TW'(TRP - 1);
  localparam logic [TW-1:0] REF_T = TW'(TRFC - 1);

  bank_state_t            state_q [NBANKS];
  bank_state_t            state_d [NBANKS];
  logic [TW-1:0]          timer_q [NBANKS];
  logic [TW-1:0]          timer_d [NBANKS];
  logic [ADDRWIDTH-1:0]   row_q   [NBANKS];

  logic [BW-1:0]          bank_idx;
  logic [7:0]             strobes;
  bank_state_t            sel;
  logic                   pra_block;
  logic                   all_idle;
  logic                   row_we;
  logic                   accept_d;
  logic                   error_d;
  logic [2:0]             code_d;
  logic                   rd_issue;

  logic                   pipe_v    [CL];
  logic [BW-1:0]          pipe_bank [CL];
  logic [COLWIDTH-1:0]    pipe_col  [CL];

  assign bank_idx = {bg, ba};
  assign strobes  = {ACT, PR, PRA, RD, RDA, WR, WRA, REF};
  assign open_row = row_q[bank_idx];
  assign rd_valid = pipe_v[CL-1];
  assign rd_bank  = pipe_bank[CL-1];
  assign rd_col   = pipe_col[CL-1];

  always_comb begin
    for (int unsigned b = 0; b < NBANKS; b++) begin
      bank_open[b] = (state_q[b] == B_ACTIVE);
    end
  end

  // Next-state: timer advance for transient banks, then command decode.
  // Commands only ever modify banks in a stable state, so they never collide
  // with the timer advance of the same bank.
  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    row_we    = 1'b0;
    accept_d  = 1'b0;
    error_d   = 1'b0;
    code_d    = err_code;
    rd_issue  = 1'b0;
    pra_block = 1'b0;
    all_idle  = 1'b1;
    sel       = state_q[bank_idx];

    for (int unsigned b = 0; b < NBANKS; b++) begin
      if (state_q[b] == B_ACTIVATING || state_q[b] == B_REFRESHING) pra_block = 1'b1;
      if (state_q[b] != B_IDLE) all_idle = 1'b0;
    end

    if (!halt) begin
      code_d = '0;

      for (int unsigned b = 0; b < NBANKS; b++) begin
        case (state_q[b])
          B_ACTIVATING, B_PRECHARGING, B_REFRESHING: begin
            if (timer_q[b] <= TW'(1)) begin
              state_d[b] = (state_q[b] == B_ACTIVATING) ? B_ACTIVE : B_IDLE;
              timer_d[b] = '0;
            end else begin
              timer_d[b] = timer_q[b] - TW'(1);
            end
          end
          default: ;
        endcase
      end

      if ($countones(strobes) > 1) begin
        error_d = 1'b1;
        code_d  = E_MULTI;
      end else if (strobes != '0) begin
        if (ACT) begin
          if (sel == B_IDLE) begin
            accept_d           = 1'b1;
            row_we             = 1'b1;
            state_d[bank_idx]  = ACT_ST;
            timer_d[bank_idx]  = ACT_T;
          end else if (sel == B_ACTIVE) begin
            error_d = 1'b1;
            code_d  = E_OPEN;
          end else begin
            error_d = 1'b1;
            code_d  = E_BUSY;
          end
        end else if (PR) begin
          if (sel == B_ACTIVE) begin
            accept_d          = 1'b1;
            state_d[bank_idx] = PRE_ST;
            timer_d[bank_idx] = PRE_T;
          end else if (sel == B_IDLE || sel == B_PRECHARGING) begin
            accept_d = 1'b1;
          end else begin
            error_d = 1'b1;
            code_d  = E_BUSY;
          end
        end else if (PRA) begin
          if (pra_block) begin
            error_d = 1'b1;
            code_d  = E_BUSY;
          end else begin
            accept_d = 1'b1;
            for (int unsigned b = 0; b < NBANKS; b++) begin
              if (state_q[b] == B_ACTIVE) begin
                state_d[b] = PRE_ST;
                timer_d[b] = PRE_T;
              end
            end
          end
        end else if (REF) begin
          if (all_idle) begin
            accept_d = 1'b1;
            for (int unsigned b = 0; b < NBANKS; b++) begin
              state_d[b] = REF_ST;
              timer_d[b] = REF_T;
            end
          end else begin
            error_d = 1'b1;
            code_d  = E_REFBLK;
          end
        end else begin
          // RD, RDA, WR, WRA
          if (sel == B_ACTIVE) begin
            accept_d = 1'b1;
            rd_issue = RD | RDA;
            if (RDA | WRA) begin
              state_d[bank_idx] = PRE_ST;
              timer_d[bank_idx] = PRE_T;
            end
          end else if (sel == B_IDLE) begin
            error_d = 1'b1;
            code_d  = E_CLOSED;
          end else begin
            error_d = 1'b1;
            code_d  = E_BUSY;
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned b = 0; b < NBANKS; b++) begin
        state_q[b] <= B_IDLE;
        timer_q[b] <= '0;
        row_q[b]   <= '0;
      end
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      if (row_we) row_q[bank_idx] <= row;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cmd_accept <= 1'b0;
      cmd_error  <= 1'b0;
      err_code   <= '0;
      for (int unsigned i = 0; i < CL; i++) begin
        pipe_v[i]    <= 1'b0;
        pipe_bank[i] <= '0;
        pipe_col[i]  <= '0;
      end
`ifdef CHIP_ERR_COUNT_EN
      err_count  <= '0;
`endif
    end else begin
      cmd_accept <= accept_d;
      cmd_error  <= error_d;
      err_code   <= code_d;
      if (!halt) begin
        pipe_v[0]    <= rd_issue;
        pipe_bank[0] <= bank_idx;
        pipe_col[0]  <= column;
        for (int unsigned i = 1; i < CL; i++) begin
          pipe_v[i]    <= pipe_v[i-1];
          pipe_bank[i] <= pipe_bank[i-1];
          pipe_col[i]  <= pipe_col[i-1];
        end
      end
`ifdef CHIP_ERR_COUNT_EN
      if (error_d && (err_count != '1)) err_count <= err_count + 16'd1;
`endif
    end
  end

endmodule
